pulse_train_tx: RTL

- Transmit side of the button-clocked counter interface. Instead of counting pulses arriving on a pin, it emits a programmed number of clean, timed pulses on a pin.
- Typical use: drive an external (or on-board) pulse counter from an on-chip request.
- Sits between a request source (debounced button, control logic) and a pmod output pin.
- Shows the remaining pulse count on 4 LEDs.

---
 rtl/pulse_train_tx.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pulse_train_tx.sv
// ---------------------------------------------------------------------------
// pulse_train_tx
//
// Purpose:
//   Transmit side of the button-clocked counter interface. On a rising edge
//   of the start request it emits count_in clean, timed pulses on pulse_out.
//   Each pulse is HIGH_CYCLES clocks high followed by LOW_CYCLES clocks low.
//   The number of pulses still to be sent is shown on led.
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        synchronous, active-high reset
//   start      request level; a 0->1 transition starts a train
//   count_in   number of pulses to send, sampled on the start edge
//   pulse_out  generated pulse train (registered)
//   busy       high while a train is in progress
//   done       single-cycle strobe when a train completes
//   led        pulses still to be sent (registered)
//
// Optional feature:
//   PULSE_TRAIN_TX_START_SYNC_EN - when defined, start passes through a
//   2-flop synchronizer before edge detection, so it may come straight from
//   an asynchronous button. Start-to-pulse latency becomes 3 cycles
//   instead of 1.
// ---------------------------------------------------------------------------
module pulse_train_tx #(
  parameter int HIGH_CYCLES = 6000000,
  parameter int LOW_CYCLES  = 6000000,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count_in,
  output logic             pulse_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] led
);

  localparam int MAX_CYC = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int TIMER_W = $clog2(MAX_CYC + 1);

  localparam logic [TIMER_W-1:0] HIGH_LAST = TIMER_W'(HIGH_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOW_LAST  = TIMER_W'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_nextTimer;
  logic [CNT_W-1:0]   r_led;
  logic [CNT_W-1:0]   w_nextLed;
  logic               r_pulse;
  logic               w_nextPulse;
  logic               r_busy;
  logic               w_nextBusy;
  logic               r_done;
  logic               w_nextDone;
  logic               r_startD;
  logic               w_startIn;
  logic               w_startRise;

`ifdef PULSE_TRAIN_TX_START_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for an asynchronous start. Both flops reset to 1
  // so a button already held during reset looks like "no new edge".
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= start;
      r_sync2 <= r_sync1;
    end
  end

  assign w_startIn = r_sync2;
`else
  assign w_startIn = start;
`endif

  // Edge-detect history. Reset to 1 so a start level held through reset
  // cannot be mistaken for a fresh request.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_startD <= 1'b1;
    end else begin
      r_startD <= w_startIn;
    end
  end

  assign w_startRise = w_startIn & ~r_startD;

  // State and datapath register. Reset forces everything quiet, which also
  // cuts a train short without producing a done strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_led   <= '0;
      r_pulse <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_timer <= w_nextTimer;
      r_led   <= w_nextLed;
      r_pulse <= w_nextPulse;
      r_busy  <= w_nextBusy;
      r_done  <= w_nextDone;
    end
  end

  // Next-state logic. The timer counts up inside each HIGH and LOW phase
  // and restarts at every phase change. led is decremented as each pulse
  // falls, so it reads 0 during the trailing low gap of the last pulse and
  // that is what sends the machine back to IDLE. Start edges outside IDLE
  // are simply not looked at, which is how requests during a train are
  // ignored.
  always_comb begin
    w_nextState = r_state;
    w_nextTimer = r_timer;
    w_nextLed   = r_led;
    w_nextPulse = r_pulse;
    w_nextBusy  = r_busy;
    w_nextDone  = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (w_startRise) begin
          if (count_in != '0) begin
            w_nextLed   = count_in;
            w_nextTimer = '0;
            w_nextBusy  = 1'b1;
            w_nextPulse = 1'b1;
            w_nextState = HIGH;
          end else begin
            w_nextDone = 1'b1;
          end
        end
      end

      HIGH: begin
        if (r_timer == HIGH_LAST) begin
          w_nextPulse = 1'b0;
          w_nextLed   = r_led - CNT_W'(1);
          w_nextTimer = '0;
          w_nextState = LOW;
        end else begin
          w_nextTimer = r_timer + TIMER_W'(1);
        end
      end

      LOW: begin
        if (r_timer == LOW_LAST) begin
          w_nextTimer = '0;
          if (r_led != '0) begin
            w_nextPulse = 1'b1;
            w_nextState = HIGH;
          end else begin
            w_nextBusy  = 1'b0;
            w_nextDone  = 1'b1;
            w_nextState = IDLE;
          end
        end else begin
          w_nextTimer = r_timer + TIMER_W'(1);
        end
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign pulse_out = r_pulse;
  assign busy      = r_busy;
  assign done      = r_done;
  assign led       = r_led;

endmodule
